// File: rtl/run_ctrl_pkg.sv
// Shared run-controller encodings: FSM states, termination status codes and
// the priority rule that picks a cause when several end conditions coincide.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RST_HOLD = 2'd1,
        ST_RUN      = 2'd2,
        ST_DONE     = 2'd3
    } run_state_e;

    typedef enum logic [1:0] {
        STATUS_NONE      = 2'd0,
        STATUS_HALT      = 2'd1,
        STATUS_SELF_LOOP = 2'd2,
        STATUS_TIMEOUT   = 2'd3
    } run_status_e;

    // Halt beats self-loop, which beats timeout.
    function automatic run_status_e term_cause(input logic halt,
                                               input logic loop_hit,
                                               input logic timeout);
        if (halt)     return STATUS_HALT;
        if (loop_hit) return STATUS_SELF_LOOP;
        if (timeout)  return STATUS_TIMEOUT;
        return STATUS_NONE;
    endfunction

endpackage

// File: rtl/cpu_run_controller_pc_loop_detector.sv
// PC self-loop detector: flags when LOOP_LIMIT consecutive samples all equal
// the previous one, i.e. LOOP_LIMIT+1 identical samples in a row.
module pc_loop_detector #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LOOP_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              sample_en,
    input  logic [ADDR_W-1:0] pc,
    output logic              loop_hit
);

    localparam int unsigned MW = (LOOP_LIMIT > 0) ? $clog2(LOOP_LIMIT + 1) : 1;
    localparam logic [MW-1:0] MATCH_MAX = MW'(LOOP_LIMIT);
    localparam logic [MW-1:0] HIT_AT    = MW'(LOOP_LIMIT - 1);

    logic [ADDR_W-1:0] pc_q;
    logic              valid_q;
    logic [MW-1:0]     match_q;
    logic              same;

    // No previous sample exists on the first RUN cycle, so no compare then.
    assign same     = valid_q && (pc == pc_q);
    assign loop_hit = (LOOP_LIMIT != 0) && sample_en && same && (match_q >= HIT_AT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            valid_q <= 1'b0;
            match_q <= '0;
        end else if (clear) begin
            pc_q    <= '0;
            valid_q <= 1'b0;
            match_q <= '0;
        end else if (sample_en) begin
            pc_q    <= pc;
            valid_q <= 1'b1;
            if (same) begin
                match_q <= (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;
            end else begin
                match_q <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller for MipsCPU: sequences CPU reset, gates its clock-enable,
// counts run cycles and ends the run on halt, PC self-loop or timeout.
module cpu_run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 50,
    parameter int unsigned LOOP_LIMIT   = 4,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              cpu_halt,
    input  logic [ADDR_W-1:0] pc,
    output logic              cpu_reset,
    output logic              cpu_run,
    output logic              done,
    output logic [1:0]        status,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int unsigned HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LAST   = HW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_CYCLES);
    localparam run_state_e       RESET_STATE = AUTO_START ? ST_RST_HOLD : ST_IDLE;

    run_state_e       state_q;
    logic [HW-1:0]    hold_q;
    logic             cpu_reset_q;
    logic             cpu_run_q;
    logic             done_q;
    run_status_e      status_q;
    logic [CNT_W-1:0] count_q;

    logic [CNT_W-1:0] count_d;
    logic             timeout;
    logic             loop_hit;
    logic             in_run;

    assign in_run  = (state_q == ST_RUN);
    assign count_d = (count_q == '1) ? count_q : count_q + 1'b1;
    // Terminal checks look at the post-increment count of the current cycle.
    assign timeout = (MAX_CYCLES != 0) && (count_d == MAX_CNT);

    pc_loop_detector #(
        .ADDR_W     (ADDR_W),
        .LOOP_LIMIT (LOOP_LIMIT)
    ) u_loop_det (
        .clock     (clock),
        .reset     (reset),
        .clear     (state_q == ST_RST_HOLD),
        .sample_en (in_run),
        .pc        (pc),
        .loop_hit  (loop_hit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            hold_q      <= '0;
            cpu_reset_q <= 1'b1;
            cpu_run_q   <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= STATUS_NONE;
            count_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_RST_HOLD;
                        hold_q      <= '0;
                        cpu_reset_q <= 1'b1;
                        cpu_run_q   <= 1'b0;
                        done_q      <= 1'b0;
                        status_q    <= STATUS_NONE;
                        count_q     <= '0;
                    end
                end
                ST_RST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q     <= ST_RUN;
                        cpu_reset_q <= 1'b0;
                        cpu_run_q   <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    count_q <= count_d;
                    // CPU is frozen rather than reset so its state stays inspectable.
                    if (cpu_halt || loop_hit || timeout) begin
                        state_q   <= ST_DONE;
                        cpu_run_q <= 1'b0;
                        done_q    <= 1'b1;
                        status_q  <= term_cause(cpu_halt, loop_hit, timeout);
                    end
                end
            endcase
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign cpu_run     = cpu_run_q;
    assign done        = done_q;
    assign status      = status_q;
    assign cycle_count = count_q;

endmodule
